// File: rtl/rom_loader.sv
// Boot-time instruction ROM loader: parses a framed byte stream, writes big-endian words to
// instruction memory, and releases the CPU once the XOR checksum over the data bytes matches.
module rom_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned BASE   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        StHdrHi,
        StHdrLo,
        StData,
        StCsum,
        StDone,
        StErr
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        count_hi_q, count_hi_d;
    logic [15:0]       count_q, count_d;
    logic [15:0]       word_idx_q, word_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       shift_q, shift_d;
    logic [7:0]        csum_q, csum_d;
    logic              in_ready_q, in_ready_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              accept;
    logic [15:0]       hdr_count;

    assign accept    = in_valid & in_ready_q;
    assign hdr_count = {count_hi_q, in_data};

    always_comb begin
        state_d    = state_q;
        count_hi_d = count_hi_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        csum_d     = csum_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        if (accept) begin
            unique case (state_q)
                StHdrHi: begin
                    count_hi_d = in_data;
                    state_d    = StHdrLo;
                end
                StHdrLo: begin
                    count_d = hdr_count;
                    if (32'(hdr_count) > DEPTH) begin
                        state_d = StErr;
                    end else if (hdr_count == 16'd0) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StData;
                    end
                end
                StData: begin
                    shift_d    = {shift_q[15:0], in_data};
                    csum_d     = csum_q ^ in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    // Fourth byte completes the word; the write strobe follows on the next cycle.
                    if (byte_idx_q == 2'd3) begin
                        wr_en_d    = 1'b1;
                        wr_data_d  = {shift_q, in_data};
                        wr_addr_d  = ADDR_W'(BASE) + ADDR_W'(word_idx_q);
                        word_idx_d = word_idx_q + 16'd1;
                        if (word_idx_q == count_q - 16'd1) begin
                            state_d = StCsum;
                        end
                    end
                end
                StCsum: begin
                    state_d = (in_data == csum_q) ? StDone : StErr;
                end
                default: ;
            endcase
        end

        in_ready_d = (state_d != StDone) && (state_d != StErr);
        done_d     = (state_d == StDone);
        err_d      = (state_d == StErr);
        // Released one cycle after DONE is entered so the pipeline sees a settled image.
        cpu_hold_d = (state_q != StDone);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StHdrHi;
            count_hi_q <= '0;
            count_q    <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            csum_q     <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= ADDR_W'(BASE);
            wr_data_q  <= '0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_hi_q <= count_hi_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            csum_q     <= csum_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: directed frames from the test plan plus randomized frames
// checked against a frame-level reference model.
module tb_rom_loader;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned BASE   = 0;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_hold;
    logic              done;
    logic              err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [ADDR_W-1:0] got_addr[$];
    logic [31:0]       got_data[$];
    logic [31:0]       exp_words[$];

    logic [7:0] nominal[$] = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05,
                               8'h00, 8'h00, 8'h00, 8'h08, 8'h2C};
    logic [31:0] nom_words[2] = '{32'h20010005, 32'h00000008};

    rom_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset && wr_en === 1'b1) begin
            got_addr.push_back(wr_addr);
            got_data.push_back(wr_data);
        end
    end

    // Frame-level model: expected words in exp_words, final done/err verdict.
    task automatic model_frame(input logic [7:0] s[$], output bit edone, output bit eerr);
        int unsigned n;
        logic [7:0]  cs;
        exp_words.delete();
        n  = {s[0], s[1]};
        cs = 8'h00;
        edone = 1'b0;
        eerr  = 1'b0;
        if (n > DEPTH) begin
            eerr = 1'b1;
            return;
        end
        for (int unsigned i = 0; i < n; i++) begin
            exp_words.push_back({s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]});
            cs = cs ^ s[2+4*i] ^ s[3+4*i] ^ s[4+4*i] ^ s[5+4*i];
        end
        if (s[2+4*n] == cs) edone = 1'b1;
        else                eerr  = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
        repeat (2) @(negedge clk);
    endtask

    task automatic release_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        got_addr.delete();
        got_data.delete();
    endtask

    // mode 0: back-to-back, 1: valid toggling plus a 10-cycle gap mid-word, 2: random gaps.
    task automatic send_bytes(input logic [7:0] s[$], input int mode);
        int guard;
        int gap;
        foreach (s[i]) begin
            gap = 0;
            if (mode == 1 && i > 0) gap = (i == 5) ? 10 : 1;
            if (mode == 2) gap = $urandom_range(0, 3);
            if (gap > 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                repeat (gap) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = s[i];
            guard = 0;
            while (in_ready !== 1'b1 && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL handshake byte %0d: in_ready=%b, required 1", i, in_ready);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err} !==
            {1'b0, 1'b0, 8'(BASE), 32'h0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b wr_en=%b addr=%h data=%h hold=%b done=%b err=%b, required 0 0 00 0 1 0 0",
                     in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err);
        end
        release_reset();
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_release: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_nominal(input int mode, input string tag);
        do_reset();
        release_reset();
        send_bytes(nominal, mode);
        n_tests++;
        if (got_data.size() != 2) begin
            n_fail++;
            $display("FAIL %s_write_count: got %0d, required 2", tag, got_data.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_tests++;
                if (got_addr[i] !== 8'(i) || got_data[i] !== nom_words[i]) begin
                    n_fail++;
                    $display("FAIL %s_write%0d: addr=%h data=%h, required addr=%h data=%h",
                             tag, i, got_addr[i], got_data[i], 8'(i), nom_words[i]);
                end
            end
        end
        n_tests++;
        if (done !== 1'b1 || err !== 1'b0 || cpu_hold !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_enter_done: done=%b err=%b hold=%b, required 1 0 1",
                     tag, done, err, cpu_hold);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_release_cpu: done=%b hold=%b rdy=%b, required 1 0 0",
                     tag, done, cpu_hold, in_ready);
        end
    endtask

    task automatic test_bad_csum();
        logic [7:0] s[$];
        s = nominal;
        s[10] = 8'h2D;
        do_reset();
        release_reset();
        send_bytes(s, 0);
        repeat (2) @(negedge clk);
        n_tests++;
        if (got_data.size() != 2 || got_data[0] !== 32'h20010005 || got_data[1] !== 32'h8) begin
            n_fail++;
            $display("FAIL badcsum_writes: count=%0d, required 2 writes 20010005,00000008",
                     got_data.size());
        end
        n_tests++;
        if (err !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL badcsum_status: err=%b done=%b hold=%b rdy=%b, required 1 0 1 0",
                     err, done, cpu_hold, in_ready);
        end
    endtask

    task automatic test_oversize();
        logic [7:0] s[$];
        s = '{8'h01, 8'h01};
        do_reset();
        release_reset();
        send_bytes(s, 0);
        n_tests++;
        if (err !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL oversize_err: err=%b rdy=%b done=%b, required 1 0 0", err, in_ready, done);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (got_data.size() != 0 || cpu_hold !== 1'b1) begin
            n_fail++;
            $display("FAIL oversize_quiet: writes=%0d hold=%b, required 0 1", got_data.size(), cpu_hold);
        end
    endtask

    task automatic test_empty();
        logic [7:0] s[$];
        s = '{8'h00, 8'h00, 8'h00};
        do_reset();
        release_reset();
        send_bytes(s, 0);
        @(negedge clk);
        n_tests++;
        if (got_data.size() != 0 || done !== 1'b1 || err !== 1'b0 || cpu_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_image: writes=%0d done=%b err=%b hold=%b, required 0 1 0 0",
                     got_data.size(), done, err, cpu_hold);
        end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        release_reset();
        send_bytes(nominal[0:6], 0);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(negedge clk);
        n_tests++;
        if ({in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err} !==
            {1'b0, 1'b0, 8'(BASE), 32'h0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL midload_reset: rdy=%b wr_en=%b addr=%h data=%h hold=%b done=%b err=%b, required 0 0 00 0 1 0 0",
                     in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err);
        end
        release_reset();
        send_bytes(nominal, 0);
        @(negedge clk);
        n_tests++;
        if (got_data.size() != 2 || got_addr[0] !== 8'd0 || got_data[0] !== 32'h20010005 ||
            got_addr[1] !== 8'd1 || got_data[1] !== 32'h8 || done !== 1'b1 || cpu_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL midload_reload: writes=%0d done=%b hold=%b, required 2 writes 1 0",
                     got_data.size(), done, cpu_hold);
        end
    endtask

    task automatic test_random();
        logic [7:0] s[$];
        int unsigned n;
        int kind;
        bit edone;
        bit eerr;
        logic [7:0] cs;
        for (int iter = 0; iter < 12; iter++) begin
            kind = $urandom_range(0, 3);
            n    = (kind == 2) ? $urandom_range(DEPTH + 1, 2000) : $urandom_range(0, 6);
            s.delete();
            s.push_back(8'(n >> 8));
            s.push_back(8'(n));
            cs = 8'h00;
            if (kind != 2) begin
                for (int unsigned i = 0; i < 4 * n; i++) begin
                    s.push_back(8'($urandom));
                    cs = cs ^ s[s.size()-1];
                end
                s.push_back(kind == 1 ? (cs ^ 8'(1 << $urandom_range(0, 7))) : cs);
            end
            model_frame(s, edone, eerr);
            do_reset();
            release_reset();
            send_bytes(s, 2);
            repeat (2) @(negedge clk);
            n_tests++;
            if (got_data.size() != exp_words.size()) begin
                n_fail++;
                $display("FAIL rand%0d_write_count: got %0d, required %0d",
                         iter, got_data.size(), exp_words.size());
            end else begin
                foreach (exp_words[i]) begin
                    n_tests++;
                    if (got_addr[i] !== 8'(BASE + i) || got_data[i] !== exp_words[i]) begin
                        n_fail++;
                        $display("FAIL rand%0d_write%0d: addr=%h data=%h, required addr=%h data=%h",
                                 iter, i, got_addr[i], got_data[i], 8'(BASE + i), exp_words[i]);
                    end
                end
            end
            n_tests++;
            if (done !== edone || err !== eerr || cpu_hold !== !edone || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL rand%0d_status: done=%b err=%b hold=%b rdy=%b, required %b %b %b 0",
                         iter, done, err, cpu_hold, in_ready, edone, eerr, !edone);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal(0, "nominal");
        test_bad_csum();
        test_oversize();
        test_empty();
        test_nominal(1, "throttled");
        test_reset_mid_load();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Boot-time loader upstream of the instruction ROM in the 5-stage pipeline.
- Accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word into instruction memory at sequential word addresses.
- Holds the CPU in reset until the whole image is loaded and the checksum is verified.

Parameters:
- ADDR_W, 8, word-address width of the instruction memory write port.
- DEPTH, 256, maximum number of words accepted (≤ 2^ADDR_W).
- BASE, 0, first word address written.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  upstream byte valid.
- in_data  input  8  upstream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- wr_en  output  1  one-cycle instruction-memory write strobe.
- wr_addr  output  ADDR_W  word address for wr_data.
- wr_data  output  32  assembled instruction word.
- cpu_hold  output  1  high keeps the CPU PC/pipeline in reset.
- done  output  1  image loaded and checksum good; sticky.
- err  output  1  framing, length or checksum failure; sticky.

Behaviour:
- Reset behaviour, on any clk edge with reset=0, including mid-load:
  - state=HDR_HI; wr_en=0, wr_addr=BASE, wr_data=0.
  - cpu_hold=1, done=0, err=0, in_ready=0.
  - Byte counter, word counter and checksum are cleared.
  - Partially loaded memory contents are not erased.
- Byte acceptance:
  - A byte transfers on a rising edge where in_valid=1 and in_ready=1. No other byte is consumed.
  - in_ready=1 in HDR_HI, HDR_LO, DATA and CSUM (first cycle after reset release onward). in_ready=0 in DONE and ERR.
- Frame format: count_hi, count_lo (16-bit word count N, big-endian), then 4*N data bytes (MSB first per word), then one checksum byte.
- Checksum: XOR of all data bytes only. Header bytes are excluded.
- HDR_HI: capture count_hi, go to HDR_LO.
- HDR_LO: capture count_lo; N = {count_hi, count_lo}.
  - N > DEPTH: go to ERR.
  - N == 0: go to CSUM.
  - Otherwise: go to DATA.
- DATA:
  - Shift each byte into the word register; XOR it into the running checksum.
  - On the 4th byte of a word: the next cycle has wr_en=1, wr_data=the assembled word, wr_addr=BASE+word_index. Single-cycle write latency after the 4th byte.
  - Byte acceptance continues without a bubble during the write.
  - After word N-1's 4th byte, go to CSUM.
- CSUM:
  - Accepted byte == running checksum: go to DONE.
  - Otherwise: go to ERR.
- DONE: done=1; cpu_hold falls to 0 on the cycle after entering DONE. Stays until reset.
- ERR: err=1, cpu_hold stays 1, in_ready=0. Stays until reset.
- Outputs done, err and cpu_hold are registered; none depend combinationally on in_valid.
- wr_addr arithmetic: wraps modulo 2^ADDR_W. The DEPTH check guarantees no wrap when BASE+DEPTH ≤ 2^ADDR_W.
- Stalls: in_valid=0 at any point holds all state; byte, word and checksum counters are unchanged.
- Reset with in_valid=1 asserted: no byte is accepted on that edge.

Test Plan:
- Nominal load:
  - Stimulus: reset release, then bytes 00 02 20 01 00 05 00 00 00 08 2C back-to-back.
  - Response: wr_en pulses twice: addr 0 = 0x20010005, addr 1 = 0x00000008. Then done=1, err=0, cpu_hold 1→0 one cycle after DONE.
- Bad checksum:
  - Stimulus: same stream with final byte 2D.
  - Response: both writes occur; then err=1, done=0, cpu_hold stays 1, in_ready=0.
- Oversize count:
  - Stimulus: DEPTH=256, header 01 01 (N=257).
  - Response: ERR right after count_lo; no wr_en pulse; err=1.
- Empty image:
  - Stimulus: bytes 00 00 00.
  - Response: no writes; done=1, cpu_hold=0.
- Throttled source:
  - Stimulus: nominal stream with in_valid toggling 1/0 every cycle, plus a 10-cycle gap mid-word.
  - Response: identical writes/addresses/data to the nominal case; no duplicate or dropped bytes.
- Reset mid-load:
  - Stimulus: assert reset=0 after 5 data bytes, release, then send the full nominal stream.
  - Response: outputs return to reset values; reload writes addr 0 = 0x20010005, addr 1 = 0x00000008; done=1.
